clock_control: RTL and testbench

Clock sequencing controller for the CPU clock. It takes the three raw front-panel buttons (run/stop, single step, speed) plus the CPU HLT signal. It debounces the buttons and runs a RUN/STOP/STEP state machine with a 4-speed programmable divider. Output is a one-cycle clock-enable `tick_o`, synchronous to `clk_i`, which the CPU datapath uses in place of a derived clock. It sits between the board I/O and the CPU core. No clock is generated or gated in fabric.

---
 rtl/clock_control.sv | 146 ++++++++++++++
 tb/tb_clock_control.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_control.sv
// CPU clock sequencer: debounced front-panel buttons drive a RUN/STOP/STEP FSM
// that emits a one-cycle clock-enable at one of four programmable rates.
module clock_control #(
  parameter int unsigned DEBOUNCE = 250000,
  parameter int unsigned DIV0     = 12500000,
  parameter int unsigned DIV1     = 1250000,
  parameter int unsigned DIV2     = 125000,
  parameter int unsigned DIV3     = 12500
) (
  input  logic       clk_i,
  input  logic       rst,
  input  logic       btn_run_i,
  input  logic       btn_step_i,
  input  logic       btn_speed_i,
  input  logic       hlt_i,
  output logic       tick_o,
  output logic       running_o,
  output logic [1:0] speed_o
);

  localparam int unsigned DB_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE - 1);

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_STOP = 2'd1,
    S_STEP = 2'd2
  } state_t;

  logic [2:0]  w_btn;
  logic [2:0]  w_evt;
  logic [31:0] w_div_last;

  state_t      r_state;
  logic [31:0] r_div;
  logic        r_tick;
  logic        r_running;
  logic [1:0]  r_speed;

  function automatic logic [31:0] div_of(input logic [1:0] s);
    case (s)
      2'd0:    div_of = 32'(DIV0);
      2'd1:    div_of = 32'(DIV1);
      2'd2:    div_of = 32'(DIV2);
      default: div_of = 32'(DIV3);
    endcase
  endfunction

  assign w_btn      = {btn_speed_i, btn_step_i, btn_run_i};
  assign w_div_last = div_of(r_speed) - 32'd1;

  // Per button: 2-FF synchronizer, hold-time debounce, rising-edge press pulse
  for (genvar gi = 0; gi < 3; gi++) begin : g_btn
    logic            r_s1;
    logic            r_s2;
    logic            r_lvl;
    logic            r_pulse;
    logic [DB_W-1:0] r_cnt;

    always_ff @(posedge clk_i or posedge rst) begin
      if (rst) begin
        r_s1 <= 1'b0;
        r_s2 <= 1'b0;
      end else begin
        r_s1 <= w_btn[gi];
        r_s2 <= r_s1;
      end
    end

    always_ff @(posedge clk_i or posedge rst) begin
      if (rst) begin
        r_cnt   <= '0;
        r_lvl   <= 1'b0;
        r_pulse <= 1'b0;
      end else if (r_s2 == r_lvl) begin
        r_cnt   <= '0;
        r_pulse <= 1'b0;
      end else if (r_cnt == DB_LAST) begin
        r_cnt   <= '0;
        r_lvl   <= r_s2;
        r_pulse <= r_s2;
      end else begin
        r_cnt   <= r_cnt + DB_W'(1);
        r_pulse <= 1'b0;
      end
    end

    assign w_evt[gi] = r_pulse;
  end

  // Sequencing FSM; halt outranks run, run outranks speed, speed outranks a due tick
  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      r_state   <= S_RUN;
      r_div     <= 32'd0;
      r_tick    <= 1'b0;
      r_running <= 1'b1;
      r_speed   <= 2'd0;
    end else begin
      r_tick <= 1'b0;
      if (w_evt[2]) begin
        r_speed <= r_speed + 2'd1;
      end
      case (r_state)
        S_RUN: begin
          if (hlt_i || w_evt[0]) begin
            r_state   <= S_STOP;
            r_running <= 1'b0;
            r_div     <= 32'd0;
          end else if (w_evt[2]) begin
            r_div <= 32'd0;
          end else if (r_div == w_div_last) begin
            r_div  <= 32'd0;
            r_tick <= 1'b1;
          end else begin
            r_div <= r_div + 32'd1;
          end
        end
        S_STOP: begin
          r_div <= 32'd0;
          if (w_evt[0] && !hlt_i) begin
            r_state   <= S_RUN;
            r_running <= 1'b1;
          end else if (w_evt[1]) begin
            r_state <= S_STEP;
            r_tick  <= 1'b1;
          end
        end
        S_STEP: begin
          r_div   <= 32'd0;
          r_state <= S_STOP;
        end
        default: begin
          r_div     <= 32'd0;
          r_state   <= S_STOP;
          r_running <= 1'b0;
        end
      endcase
    end
  end

  assign tick_o    = r_tick;
  assign running_o = r_running;
  assign speed_o   = r_speed;

endmodule

// File: tb/tb_clock_control.sv
// Bench for clock_control: vector table, hand-written corner sequences and a
// random phase, all checked cycle by cycle against a reference model.
module tb_clock_control;

  localparam int DEB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn_run = 1'b0;
  logic       btn_step = 1'b0;
  logic       btn_speed = 1'b0;
  logic       hlt = 1'b0;
  logic       tick;
  logic       running;
  logic [1:0] speed;

  int errors = 0;
  int checks = 0;
  int n_ticks = 0;

  // Reference model: absolute cycle count and due time of the next tick
  int             m_cyc;
  int             m_due;
  int             m_mode;   // 0 run, 1 stop, 2 step
  int             m_spd;
  logic           m_tick;
  logic [2:0]     m_db;
  logic [2:0]     m_evt;
  logic [DEB+1:0] m_hist [3];

  typedef struct {
    logic run;
    logic step;
    logic spd;
    logic h;
    int   n;
    int   exp_running;
    int   exp_speed;
    int   exp_ticks;
  } vec_t;

  vec_t tbl [17];

  clock_control #(
    .DEBOUNCE(4), .DIV0(8), .DIV1(4), .DIV2(3), .DIV3(2)
  ) dut (
    .clk_i(clk), .rst(rst), .btn_run_i(btn_run), .btn_step_i(btn_step),
    .btn_speed_i(btn_speed), .hlt_i(hlt), .tick_o(tick),
    .running_o(running), .speed_o(speed)
  );

  always #5 clk = ~clk;

  function automatic int div_of(input int s);
    case (s)
      0: return 8;
      1: return 4;
      2: return 3;
      default: return 2;
    endcase
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at t=%0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_cyc  = 0;
    m_mode = 0;
    m_spd  = 0;
    m_due  = div_of(0);
    m_tick = 1'b0;
    m_db   = 3'b000;
    m_evt  = 3'b000;
    for (int b = 0; b < 3; b++) m_hist[b] = '0;
  endtask

  task automatic model_edge(input logic [2:0] raw, input logic h);
    logic [2:0] ev;
    int         nspd;
    m_cyc++;
    ev     = m_evt;
    nspd   = (m_spd + int'(ev[2])) % 4;
    m_tick = 1'b0;
    if (m_mode == 0) begin
      if (h || ev[0]) m_mode = 1;
      else if (ev[2]) m_due = m_cyc + div_of(nspd);
      else if (m_cyc == m_due) begin
        m_tick = 1'b1;
        m_due  = m_cyc + div_of(m_spd);
      end
    end else if (m_mode == 1) begin
      if (ev[0] && !h) begin
        m_mode = 0;
        m_due  = m_cyc + div_of(nspd);
      end else if (ev[1]) begin
        m_mode = 2;
        m_tick = 1'b1;
      end
    end else begin
      m_mode = 1;
    end
    m_spd = nspd;
    // A level is accepted once the last DEB synchronized samples all disagree with it
    for (int b = 0; b < 3; b++) begin
      m_hist[b] = {m_hist[b][DEB:0], raw[b]};
      if (m_hist[b][DEB+1:2] == {DEB{~m_db[b]}}) begin
        m_db[b]  = ~m_db[b];
        m_evt[b] = m_db[b];
      end else begin
        m_evt[b] = 1'b0;
      end
    end
  endtask

  task automatic cyc_step();
    @(posedge clk);
    #1;
    model_edge({btn_speed, btn_step, btn_run}, hlt);
    check("tick", int'(tick), int'(m_tick));
    check("running", int'(running), (m_mode == 0) ? 1 : 0);
    check("speed", int'(speed), m_spd);
    if (tick) n_ticks++;
  endtask

  task automatic hold(input logic r, input logic s, input logic sp, input int n);
    btn_run   = r;
    btn_step  = s;
    btn_speed = sp;
    for (int i = 0; i < n; i++) cyc_step();
  endtask

  task automatic press(input logic r, input logic s, input logic sp);
    hold(r, s, sp, 8);
    hold(1'b0, 1'b0, 1'b0, 8);
  endtask

  // Asserted between edges so the async path is exercised mid-count
  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    check("rst_tick", int'(tick), 0);
    check("rst_running", int'(running), 1);
    check("rst_speed", int'(speed), 0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_tick(output int cycles);
    cycles = 0;
    do begin
      cyc_step();
      cycles++;
    end while (!tick && cycles < 40);
    if (!tick) begin
      checks++;
      errors++;
      $display("FAIL wait_tick: no tick within %0d cycles", cycles);
    end
  endtask

  initial begin
    int t0;
    int per;
    int exp_spd [4];
    int exp_per [4];

    tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 40, 1, 0, 5};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8, 0, 0, 0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8, 0, 0, 0};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8, 0, 0, 1};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8, 0, 0, 0};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8, 0, 0, 1};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8, 0, 0, 0};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8, 0, 0, 1};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8, 0, 0, 0};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8, 0, 1, 0};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 8, 0, 1, 0};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b1, 8, 0, 1, 0};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 8, 0, 1, 0};
    tbl[13] = '{1'b0, 1'b1, 1'b0, 1'b1, 8, 0, 1, 1};
    tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b1, 8, 0, 1, 0};
    tbl[15] = '{1'b1, 1'b1, 1'b0, 1'b0, 8, 1, 1, 0};
    tbl[16] = '{1'b0, 1'b0, 1'b0, 1'b0, 8, 1, 1, 2};
    exp_spd = '{1, 2, 3, 0};
    exp_per = '{4, 3, 2, 8};

    #1;
    do_reset();

    for (int v = 0; v < 17; v++) begin
      hlt = tbl[v].h;
      t0  = n_ticks;
      hold(tbl[v].run, tbl[v].step, tbl[v].spd, tbl[v].n);
      check($sformatf("vec%0d_running", v), int'(running), tbl[v].exp_running);
      check($sformatf("vec%0d_speed", v), int'(speed), tbl[v].exp_speed);
      check($sformatf("vec%0d_ticks", v), n_ticks - t0, tbl[v].exp_ticks);
    end

    // Bouncing run button: only the final stable hold may count
    hlt = 1'b0;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      hold(1'b1, 1'b0, 1'b0, 2);
      hold(1'b0, 1'b0, 1'b0, 2);
    end
    check("glitch_still_running", int'(running), 1);
    hold(1'b1, 1'b0, 1'b0, 10);
    check("glitch_stopped", int'(running), 0);
    t0 = n_ticks;
    hold(1'b0, 1'b0, 1'b0, 20);
    check("glitch_no_ticks", n_ticks - t0, 0);

    // Speed cycling with period measured after each change
    do_reset();
    for (int i = 0; i < 4; i++) begin
      press(1'b0, 1'b0, 1'b1);
      check($sformatf("speed_step%0d", i), int'(speed), exp_spd[i]);
      wait_tick(per);
      wait_tick(per);
      check($sformatf("period_speed%0d", exp_spd[i]), per, exp_per[i]);
    end

    // Halt exactly where the divider would have wrapped
    wait_tick(per);
    hold(1'b0, 1'b0, 1'b0, 7);
    hlt = 1'b1;
    cyc_step();
    check("halt_no_tick", int'(tick), 0);
    check("halt_stopped", int'(running), 0);
    press(1'b1, 1'b0, 1'b0);
    check("halt_run_ignored", int'(running), 0);
    t0 = n_ticks;
    press(1'b0, 1'b1, 1'b0);
    check("halt_step_ticks", n_ticks - t0, 1);
    hlt = 1'b0;
    press(1'b1, 1'b0, 1'b0);
    check("unhalt_run", int'(running), 1);

    // Reset mid-count and mid-debounce, with the button still held afterwards
    press(1'b0, 1'b0, 1'b1);
    hold(1'b1, 1'b0, 1'b0, 3);
    do_reset();
    hold(1'b1, 1'b0, 1'b0, 10);
    check("held_through_reset", int'(running), 0);
    hold(1'b0, 1'b0, 1'b0, 8);

    // Random buttons and halt against the model
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 11) == 0) btn_run = ~btn_run;
      if ($urandom_range(0, 11) == 0) btn_step = ~btn_step;
      if ($urandom_range(0, 11) == 0) btn_speed = ~btn_speed;
      if ($urandom_range(0, 19) == 0) hlt = ~hlt;
      cyc_step();
      if ($urandom_range(0, 499) == 0) do_reset();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
